// File: rtl/lcd_frame_reader_pkg.sv
// Shared types and HD44780 command constants for the LCD frame reader.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_LINE_CMD,
    ST_FETCH,
    ST_CHAR,
    ST_FRAME_END
  } state_t;

  typedef enum logic [2:0] {
    BW_IDLE,
    BW_SETUP,
    BW_E_HIGH,
    BW_HOLD,
    BW_WAIT
  } bus_state_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  // Element 0 is the first command sent.
  localparam logic [3:0][7:0] INIT_CMDS = {LCD_CLEAR, LCD_ENTRY, LCD_DISP_ON, LCD_FUNC_SET};

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_frame_reader_if.sv
// Register-file read port plus LCD pins as seen by the frame reader.
interface lcd_frame_reader_if;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic [7:0]  lcd_data;
  logic        init_done;
  logic        frame_done;

  modport master (
    output rd_addr, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done,
    input  rd_data
  );

  modport slave (
    input  rd_addr, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done,
    output rd_data
  );
endinterface

// File: rtl/lcd_bus_writer.sv
// One HD44780 bus write per start: SETUP, E_HIGH, HOLD, WAIT, then a done pulse.
// Optional macro LCD_CHAR_FILTER_EN replaces non-printable data bytes with '.'.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYC  = 12,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int CW = $clog2(max3(E_PULSE_CYC, CMD_WAIT_CYC, CLR_WAIT_CYC) + 1);
  localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT_CYC - 1);

  bus_state_t    state;
  logic [CW-1:0] cnt;
  logic          is_clear;
  logic [7:0]    shown;

  always_comb begin
    shown = data;
`ifdef LCD_CHAR_FILTER_EN
    if (rs && (data < 8'h20 || data > 8'h7E)) shown = 8'h2E;
`endif
  end

  assign done = (state == BW_WAIT) && (cnt == (is_clear ? CLR_LAST : CMD_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BW_IDLE;
      cnt      <= '0;
      is_clear <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      case (state)
        BW_IDLE: if (start) begin
          lcd_rs   <= rs;
          lcd_data <= shown;
          is_clear <= !rs && (data == LCD_CLEAR);
          state    <= BW_SETUP;
        end
        BW_SETUP: begin
          lcd_e <= 1'b1;
          cnt   <= '0;
          state <= BW_E_HIGH;
        end
        BW_E_HIGH: if (cnt == E_LAST) begin
          lcd_e <= 1'b0;
          state <= BW_HOLD;
        end else cnt <= cnt + 1'b1;
        BW_HOLD: begin
          cnt   <= '0;
          state <= BW_WAIT;
        end
        BW_WAIT: if (done) state <= BW_IDLE;
                 else cnt <= cnt + 1'b1;
        default: state <= BW_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    assert (E_PULSE_CYC > 0 && CMD_WAIT_CYC > 0 && CLR_WAIT_CYC > 0)
      else $error("lcd_bus_writer: timing parameters must be non-zero");
  end

endmodule

// File: rtl/lcd_frame_reader.sv
// Scans 8 character words from the register file and refreshes a 16x2 HD44780 LCD.
// Optional macro LCD_CHAR_FILTER_EN (handled in lcd_bus_writer) masks non-printable characters.
module lcd_frame_reader
  import lcd_pkg::*;
#(
  parameter int NUM_WORDS    = 8,
  parameter int BASE_ADDR    = 0,
  parameter int E_PULSE_CYC  = 12,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int PWR_WAIT_CYC = 2000000
) (
  input logic                clk,
  input logic                rst,
  lcd_frame_reader_if.master bus
);

  localparam int PW = $clog2(PWR_WAIT_CYC + 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(PWR_WAIT_CYC - 1);
  localparam logic [3:0]    BASE     = 4'(BASE_ADDR);

  state_t        state;
  logic [PW-1:0] pwr_cnt;
  logic [1:0]    init_idx;
  logic [1:0]    char_idx;
  logic [2:0]    word_idx;
  logic          line2;
  logic          pending;
  logic [31:0]   word;
  logic [3:0]    rd_addr;
  logic          init_done;
  logic          frame_done;
  logic          start;
  logic          rs;
  logic [7:0]    data;
  logic          done;
  logic          lcd_e;
  logic          lcd_rs;
  logic [7:0]    lcd_data;

  always_comb begin
    rs   = 1'b0;
    data = 8'h00;
    case (state)
      ST_INIT:     data = INIT_CMDS[init_idx];
      ST_LINE_CMD: data = line2 ? LCD_LINE2 : LCD_LINE1;
      ST_CHAR: begin
        rs   = 1'b1;
        data = word[31 - 8*char_idx -: 8];
      end
      default: ;
    endcase
  end

  // A write is requested once per visit to a byte-issuing state; done advances the sequence.
  assign start = !pending && (state == ST_INIT || state == ST_LINE_CMD || state == ST_CHAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_PWR_WAIT;
      pwr_cnt    <= '0;
      init_idx   <= '0;
      char_idx   <= '0;
      word_idx   <= '0;
      line2      <= 1'b0;
      pending    <= 1'b0;
      word       <= '0;
      rd_addr    <= BASE;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start) pending <= 1'b1;
      else if (done) pending <= 1'b0;
      case (state)
        ST_PWR_WAIT: if (pwr_cnt == PWR_LAST) state <= ST_INIT;
                     else pwr_cnt <= pwr_cnt + 1'b1;
        ST_INIT: if (done) begin
          if (init_idx == 2'd3) begin
            init_done <= 1'b1;
            line2     <= 1'b0;
            state     <= ST_LINE_CMD;
          end else init_idx <= init_idx + 1'b1;
        end
        ST_LINE_CMD: if (done) state <= ST_FETCH;
        ST_FETCH: begin
          word     <= bus.rd_data;
          char_idx <= '0;
          state    <= ST_CHAR;
        end
        ST_CHAR: if (done) begin
          if (char_idx == 2'd3) begin
            rd_addr  <= rd_addr + 1'b1;
            word_idx <= word_idx + 1'b1;
            if (word_idx == 3'd3) begin
              line2 <= 1'b1;
              state <= ST_LINE_CMD;
            end else if (word_idx == 3'd7) begin
              frame_done <= 1'b1;
              state      <= ST_FRAME_END;
            end else state <= ST_FETCH;
          end else char_idx <= char_idx + 1'b1;
        end
        ST_FRAME_END: begin
          rd_addr <= BASE;
          line2   <= 1'b0;
          state   <= ST_LINE_CMD;
        end
        default: state <= ST_PWR_WAIT;
      endcase
    end
  end

  lcd_bus_writer #(
    .E_PULSE_CYC (E_PULSE_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) u_writer (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rs      (rs),
    .data    (data),
    .done    (done),
    .lcd_e   (lcd_e),
    .lcd_rs  (lcd_rs),
    .lcd_data(lcd_data)
  );

  assign bus.rd_addr    = rd_addr;
  assign bus.lcd_rs     = lcd_rs;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_e      = lcd_e;
  assign bus.lcd_data   = lcd_data;
  assign bus.init_done  = init_done;
  assign bus.frame_done = frame_done;

  always @(posedge clk) begin
    assert (NUM_WORDS == 8 && PWR_WAIT_CYC > 0)
      else $error("lcd_frame_reader: illegal parameters");
  end

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Directed testbench for lcd_frame_reader: init sequence, frame content, write timing, snapshot and reset.
module tb_lcd_frame_reader;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         high;
    bit         stable;
  } wr_t;

  logic        clk;
  logic        rst;
  logic [31:0] mem [16];
  wr_t         recs [$];
  wr_t         cur;
  logic        prev_e;
  logic        prev_rs;
  logic [7:0]  prev_data;
  int          fd_count;
  int          errors;
  int          checks;

  lcd_frame_reader_if bus();

  lcd_frame_reader #(
    .NUM_WORDS   (8),
    .BASE_ADDR   (0),
    .E_PULSE_CYC (2),
    .CMD_WAIT_CYC(5),
    .CLR_WAIT_CYC(15),
    .PWR_WAIT_CYC(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.rd_data = mem[bus.rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every bus write: bytes seen at E rise, E width, and bus stability SETUP..HOLD.
  always @(negedge clk) begin
    if (bus.lcd_e && !prev_e) begin
      cur.data   = bus.lcd_data;
      cur.rs     = bus.lcd_rs;
      cur.high   = 1;
      cur.stable = (bus.lcd_data === prev_data) && (bus.lcd_rs === prev_rs);
    end else if (bus.lcd_e) begin
      cur.high = cur.high + 1;
      if (bus.lcd_data !== prev_data || bus.lcd_rs !== prev_rs) cur.stable = 1'b0;
    end else if (prev_e) begin
      if (bus.lcd_data !== prev_data || bus.lcd_rs !== prev_rs) cur.stable = 1'b0;
      recs.push_back(cur);
    end
    if (bus.frame_done === 1'b1) fd_count = fd_count + 1;
    prev_e    = bus.lcd_e;
    prev_data = bus.lcd_data;
    prev_rs   = bus.lcd_rs;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_recs(input int n);
    int guard;
    guard = 0;
    while (recs.size() < n && guard < 3000) begin
      step();
      guard++;
    end
    checks++;
    if (recs.size() < n) begin
      errors++;
      $display("[TB] FAIL wait_recs: got %0d writes, need %0d", recs.size(), n);
    end
  endtask

  task automatic wait_e_high();
    int guard;
    guard = 0;
    while (bus.lcd_e !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    checks++;
    if (bus.lcd_e !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_e_high: lcd_e=%b after %0d cycles", bus.lcd_e, guard);
    end
  endtask

  task automatic check_power_wait();
    int e_seen;
    e_seen = 0;
    repeat (20) begin
      step();
      if (bus.lcd_e !== 1'b0) e_seen++;
    end
    checks++;
    if (e_seen !== 0) begin
      errors++;
      $display("[TB] FAIL pwr_wait: lcd_e high %0d cycles, need 0", e_seen);
    end
  endtask

  task automatic test_reset();
    mem[0] = "HELL";
    mem[1] = "O WO";
    mem[2] = "RLD ";
    mem[3] = "    ";
    mem[4] = "LINE";
    mem[5] = "2 OK";
    mem[6] = "    ";
    mem[7] = "    ";
    for (int i = 8; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.rd_addr !== 4'h0) begin errors++; $display("[TB] FAIL rst_rd_addr: got %h need 0", bus.rd_addr); end
    checks++;
    if (bus.lcd_e !== 1'b0) begin errors++; $display("[TB] FAIL rst_lcd_e: got %b need 0", bus.lcd_e); end
    checks++;
    if (bus.lcd_rs !== 1'b0) begin errors++; $display("[TB] FAIL rst_lcd_rs: got %b need 0", bus.lcd_rs); end
    checks++;
    if (bus.lcd_rw !== 1'b0) begin errors++; $display("[TB] FAIL rst_lcd_rw: got %b need 0", bus.lcd_rw); end
    checks++;
    if (bus.lcd_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_lcd_data: got %h need 00", bus.lcd_data); end
    checks++;
    if (bus.init_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_init_done: got %b need 0", bus.init_done); end
    checks++;
    if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done: got %b need 0", bus.frame_done); end
    recs.delete();
    fd_count = 0;
    rst = 1'b0;
    check_power_wait();
  endtask

  task automatic test_init();
    logic [7:0] exp [4];
    int cnt;
    exp[0] = 8'h38; exp[1] = 8'h0C; exp[2] = 8'h06; exp[3] = 8'h01;
    wait_recs(4);
    // Sample now is the HOLD cycle of the clear command.
    cnt = 0;
    while (bus.init_done !== 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
    for (int i = 0; i < 4 && i < recs.size(); i++) begin
      checks++;
      if (recs[i].data !== exp[i] || recs[i].rs !== 1'b0) begin
        errors++;
        $display("[TB] FAIL init_cmd%0d: got %h rs=%b, need %h rs=0", i, recs[i].data, recs[i].rs, exp[i]);
      end
    end
    // HOLD cycle plus the 15-cycle clear wait
    checks++;
    if (cnt !== 16) begin
      errors++;
      $display("[TB] FAIL init_done_delay: got %0d cycles after E fall, need 16", cnt);
    end
  endtask

  task automatic test_frame(input int base, input string l1, input string l2, input int exp_fd);
    logic [7:0] exp;
    logic       exp_rs;
    wait_recs(base + 35);
    for (int k = 0; k < 34 && base + k < recs.size(); k++) begin
      if (k == 0) begin
        exp = 8'h80; exp_rs = 1'b0;
      end else if (k == 17) begin
        exp = 8'hC0; exp_rs = 1'b0;
      end else if (k < 17) begin
        exp = l1[k-1]; exp_rs = 1'b1;
      end else begin
        exp = l2[k-18]; exp_rs = 1'b1;
      end
      checks++;
      if (recs[base+k].data !== exp || recs[base+k].rs !== exp_rs) begin
        errors++;
        $display("[TB] FAIL frame@%0d write%0d: got %h rs=%b, need %h rs=%b",
                 base, k, recs[base+k].data, recs[base+k].rs, exp, exp_rs);
      end
    end
    checks++;
    if (fd_count !== exp_fd) begin
      errors++;
      $display("[TB] FAIL frame_done_count: got %0d need %0d", fd_count, exp_fd);
    end
  endtask

  task automatic test_timing();
    for (int i = 0; i < recs.size(); i++) begin
      checks++;
      if (recs[i].high !== 2 || recs[i].stable !== 1'b1) begin
        errors++;
        $display("[TB] FAIL timing write%0d: e_high=%0d stable=%b, need 2 and 1", i, recs[i].high, recs[i].stable);
      end
    end
  endtask

  task automatic test_snapshot();
    // Frame 2: 0x80 at 38, 'H' at 39; change word 0 while 'E' is on the bus.
    wait_recs(40);
    wait_e_high();
    mem[0] = "ABCD";
    test_frame(38, "HELLO WORLD     ", "LINE2 OK        ", 2);
    test_frame(72, "ABCDO WORLD     ", "LINE2 OK        ", 3);
  endtask

  task automatic test_reset_mid();
    // Frame 4 starts at 106; 0xC0 at 123, line-2 characters from 124.
    wait_recs(126);
    wait_e_high();
    rst    = 1'b1;
    mem[0] = 32'h41077F42;
    step();
    checks++;
    if (bus.lcd_e !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_lcd_e: got %b need 0", bus.lcd_e); end
    checks++;
    if (bus.rd_addr !== 4'h0) begin errors++; $display("[TB] FAIL mid_rst_rd_addr: got %h need 0", bus.rd_addr); end
    checks++;
    if (bus.init_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_init_done: got %b need 0", bus.init_done); end
    recs.delete();
    fd_count = 0;
    rst = 1'b0;
    check_power_wait();
    test_init();
  endtask

  task automatic test_filter();
    logic [7:0] exp [4];
`ifdef LCD_CHAR_FILTER_EN
    exp[0] = 8'h41; exp[1] = 8'h2E; exp[2] = 8'h2E; exp[3] = 8'h42;
`else
    exp[0] = 8'h41; exp[1] = 8'h07; exp[2] = 8'h7F; exp[3] = 8'h42;
`endif
    wait_recs(9);
    checks++;
    if (recs.size() > 4 && (recs[4].data !== 8'h80 || recs[4].rs !== 1'b0)) begin
      errors++;
      $display("[TB] FAIL filter_line1: got %h rs=%b, need 80 rs=0", recs[4].data, recs[4].rs);
    end
    for (int i = 0; i < 4 && 5 + i < recs.size(); i++) begin
      checks++;
      if (recs[5+i].data !== exp[i] || recs[5+i].rs !== 1'b1) begin
        errors++;
        $display("[TB] FAIL filter_char%0d: got %h rs=%b, need %h rs=1", i, recs[5+i].data, recs[5+i].rs, exp[i]);
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    fd_count  = 0;
    prev_e    = 1'b0;
    prev_rs   = 1'b0;
    prev_data = 8'h00;
    rst       = 1'b1;
    test_reset();
    test_init();
    test_frame(4, "HELLO WORLD     ", "LINE2 OK        ", 1);
    test_snapshot();
    test_timing();
    test_reset_mid();
    test_filter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
